// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared definitions for the frame-buffer datapath: controller
//                state encoding and the pixel-count / address-width
//                derivation used by frame_buffer_controller and frame_buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package fb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CLEAR       = 3'd1,
        ST_DRAW        = 3'd2,
        ST_WAIT_VBLANK = 3'd3,
        ST_SWAP        = 3'd4
    } fb_state_e;

    localparam int C_DEFAULT_HOR_ACTIVE = 640;
    localparam int C_DEFAULT_VER_ACTIVE = 480;

    function automatic int fb_total_pixels(input int hor, input int ver);
        return hor * ver;
    endfunction

    // A one-pixel store still needs a one-bit address port.
    function automatic int fb_addr_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage : fb_pkg
`default_nettype wire

// File: rtl/fb_clear_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fb_clear_engine
//  Description : Address generator for clearing the back buffer. A start pulse
//                launches a sweep 0..TOTAL_PIXELS-1, one address per cycle.
//                The counter saturates at the last address and never wraps.
//  Revision    : 1.0  initial release
//  Ports       : clk      system clock
//                rst_n    asynchronous active-low reset
//                start_i  pulse: restart the sweep at address 0
//                addr_o   current clear address
//                valid_o  addr_o is a live clear address this cycle
//                last_o   addr_o is the final pixel (TOTAL_PIXELS-1)
// ============================================================================
module fb_clear_engine #(
    parameter int TOTAL_PIXELS = 32,
    parameter int ADDR_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  valid_o,
    output logic                  last_o
);

    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(TOTAL_PIXELS - 1);

    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic                  active_q, active_d;
    logic                  w_last;

    assign w_last  = active_q && (count_q == C_LAST_ADDR);
    assign addr_o  = count_q;
    assign valid_o = active_q;
    assign last_o  = w_last;

    always_comb begin
        count_d  = count_q;
        active_d = active_q;
        if (start_i) begin
            count_d  = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            // Hold at the last address once reached so the counter cannot wrap.
            if (w_last) begin
                active_d = 1'b0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
        end
    end

endmodule : fb_clear_engine
`default_nettype wire

// File: rtl/frame_buffer_controller.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buffer_controller
//  Description : Sequences one frame of drawing into the double-buffered
//                frame store: optional clear of the back buffer, pass-through
//                of drawer writes, then a single-cycle swap on the first
//                vertical blank after the drawer reports completion.
//  Revision    : 1.0  initial release
//  Ports       : clk             system clock
//                rst_n           asynchronous active-low reset
//                frame_start     pulse: begin a frame (IDLE only)
//                draw_valid      drawer pixel write request
//                draw_addr       drawer pixel address, row-major
//                draw_data       drawer pixel value
//                draw_ready      drawer writes accepted (DRAW only)
//                draw_done       pulse: drawer finished the frame
//                vblank_start    pulse: first cycle of vertical blanking
//                fb_write_enable frame_buffer write enable (registered)
//                fb_write_addr   frame_buffer write address (registered)
//                fb_write_data   frame_buffer write data (registered)
//                fb_swap         frame_buffer swap, one-cycle pulse
//                busy            high in every state except IDLE
// ============================================================================
module frame_buffer_controller
    import fb_pkg::*;
#(
    parameter  int HOR_ACTIVE_PIXELS = C_DEFAULT_HOR_ACTIVE,
    parameter  int VER_ACTIVE_PIXELS = C_DEFAULT_VER_ACTIVE,
    parameter  int CLEAR_ON_START    = 1,
    localparam int TOTAL_PIXELS      = fb_total_pixels(HOR_ACTIVE_PIXELS, VER_ACTIVE_PIXELS),
    localparam int ADDR_WIDTH        = fb_addr_width(TOTAL_PIXELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  draw_valid,
    input  logic [ADDR_WIDTH-1:0] draw_addr,
    input  logic                  draw_data,
    output logic                  draw_ready,
    input  logic                  draw_done,
    input  logic                  vblank_start,
    output logic                  fb_write_enable,
    output logic [ADDR_WIDTH-1:0] fb_write_addr,
    output logic                  fb_write_data,
    output logic                  fb_swap,
    output logic                  busy
);

    fb_state_e             state_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  data_q;
    logic                  swap_q;

    logic                  w_clr_start;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_clr_valid;
    logic                  w_clr_last;
    logic                  w_addr_in_range;

    // One extra bit keeps the comparison exact when TOTAL_PIXELS is a power of two.
    assign w_addr_in_range = ({1'b0, draw_addr} < (ADDR_WIDTH + 1)'(TOTAL_PIXELS));

    assign w_clr_start = (state_q == ST_IDLE) && frame_start;

    generate
        if (CLEAR_ON_START != 0) begin : g_clear
            fb_clear_engine #(
                .TOTAL_PIXELS (TOTAL_PIXELS),
                .ADDR_WIDTH   (ADDR_WIDTH)
            ) u_clear (
                .clk     (clk),
                .rst_n   (rst_n),
                .start_i (w_clr_start),
                .addr_o  (w_clr_addr),
                .valid_o (w_clr_valid),
                .last_o  (w_clr_last)
            );
        end else begin : g_no_clear
            assign w_clr_addr  = '0;
            assign w_clr_valid = 1'b0;
            assign w_clr_last  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= 1'b0;
            swap_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            swap_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_q <= (CLEAR_ON_START != 0) ? ST_CLEAR : ST_DRAW;
                    end
                end
                ST_CLEAR: begin
                    if (w_clr_valid) begin
                        we_q   <= 1'b1;
                        addr_q <= w_clr_addr;
                        data_q <= 1'b0;
                        if (w_clr_last) begin
                            state_q <= ST_DRAW;
                        end
                    end
                end
                ST_DRAW: begin
                    // Out-of-range writes are handshaken but never reach the store.
                    if (draw_valid && w_addr_in_range) begin
                        we_q   <= 1'b1;
                        addr_q <= draw_addr;
                        data_q <= draw_data;
                    end
                    // A vblank in this same cycle is deliberately not seen.
                    if (draw_done) begin
                        state_q <= ST_WAIT_VBLANK;
                    end
                end
                ST_WAIT_VBLANK: begin
                    if (vblank_start) begin
                        swap_q  <= 1'b1;
                        state_q <= ST_SWAP;
                    end
                end
                ST_SWAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fb_write_enable = we_q;
    assign fb_write_addr   = addr_q;
    assign fb_write_data   = data_q;
    assign fb_swap         = swap_q;
    assign busy            = (state_q != ST_IDLE);
    assign draw_ready      = (state_q == ST_DRAW);

endmodule : frame_buffer_controller
`default_nettype wire

// File: tb/tb_frame_buffer_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_buffer_controller
//  Description : Directed self-checking bench. Instance dut uses an 8x4
//                store with clear-on-start; instance dut2 uses an 8x5 store
//                (6-bit address, so addresses past the last pixel exist)
//                with clear disabled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_buffer_controller;

    logic clk;
    logic rst_n;

    // dut: 8x4 = 32 pixels, 5-bit address
    logic       frame_start, draw_valid, draw_data, draw_done, vblank_start;
    logic [4:0] draw_addr;
    logic       draw_ready, fb_write_enable, fb_write_data, fb_swap, busy;
    logic [4:0] fb_write_addr;

    // dut2: 8x5 = 40 pixels, 6-bit address, no clear
    logic       frame_start2, draw_valid2, draw_data2, draw_done2, vblank_start2;
    logic [5:0] draw_addr2;
    logic       draw_ready2, fb_write_enable2, fb_write_data2, fb_swap2, busy2;
    logic [5:0] fb_write_addr2;

    int checks = 0;
    int errors = 0;

    frame_buffer_controller #(
        .HOR_ACTIVE_PIXELS (8),
        .VER_ACTIVE_PIXELS (4),
        .CLEAR_ON_START    (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .draw_valid      (draw_valid),
        .draw_addr       (draw_addr),
        .draw_data       (draw_data),
        .draw_ready      (draw_ready),
        .draw_done       (draw_done),
        .vblank_start    (vblank_start),
        .fb_write_enable (fb_write_enable),
        .fb_write_addr   (fb_write_addr),
        .fb_write_data   (fb_write_data),
        .fb_swap         (fb_swap),
        .busy            (busy)
    );

    frame_buffer_controller #(
        .HOR_ACTIVE_PIXELS (8),
        .VER_ACTIVE_PIXELS (5),
        .CLEAR_ON_START    (0)
    ) dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start2),
        .draw_valid      (draw_valid2),
        .draw_addr       (draw_addr2),
        .draw_data       (draw_data2),
        .draw_ready      (draw_ready2),
        .draw_done       (draw_done2),
        .vblank_start    (vblank_start2),
        .fb_write_enable (fb_write_enable2),
        .fb_write_addr   (fb_write_addr2),
        .fb_write_data   (fb_write_data2),
        .fb_swap         (fb_swap2),
        .busy            (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs set after this are
    // sampled at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({fb_write_enable, fb_write_addr, fb_write_data, fb_swap, busy, draw_ready} !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b addr=%0d data=%b swap=%b busy=%b ready=%b, want all 0",
                     fb_write_enable, fb_write_addr, fb_write_data, fb_swap, busy, draw_ready);
        end
        checks++;
        if ({fb_write_enable2, fb_write_addr2, fb_write_data2, fb_swap2, busy2, draw_ready2} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs2: got we=%b addr=%0d swap=%b busy=%b ready=%b, want all 0",
                     fb_write_enable2, fb_write_addr2, fb_swap2, busy2, draw_ready2);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || fb_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b we=%b, want 0 0", busy, fb_write_enable);
        end
    endtask

    // Full 32-cycle clear into DRAW.
    task automatic test_clear();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || draw_ready !== 1'b0 || fb_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL clear_entry: busy=%b ready=%b we=%b, want 1 0 0", busy, draw_ready, fb_write_enable);
        end
        for (int k = 0; k < 32; k++) begin
            tick();
            checks++;
            if (fb_write_enable !== 1'b1 || fb_write_addr !== 5'(k) || fb_write_data !== 1'b0) begin
                errors++;
                $display("FAIL clear_write[%0d]: we=%b addr=%0d data=%b, want 1 %0d 0",
                         k, fb_write_enable, fb_write_addr, fb_write_data, k);
            end
            checks++;
            if (draw_ready !== ((k == 31) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL clear_ready[%0d]: ready=%b, want %b", k, draw_ready, (k == 31));
            end
        end
        tick();
        checks++;
        if (fb_write_enable !== 1'b0 || draw_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_done: we=%b ready=%b, want 0 1", fb_write_enable, draw_ready);
        end
    endtask

    task automatic test_draw_write();
        draw_valid = 1'b1; draw_addr = 5'd5; draw_data = 1'b1;
        tick();
        checks++;
        if (fb_write_enable !== 1'b1 || fb_write_addr !== 5'd5 || fb_write_data !== 1'b1) begin
            errors++;
            $display("FAIL draw_addr5: we=%b addr=%0d data=%b, want 1 5 1", fb_write_enable, fb_write_addr, fb_write_data);
        end
        draw_addr = 5'd31; draw_data = 1'b1;
        tick();
        checks++;
        if (fb_write_enable !== 1'b1 || fb_write_addr !== 5'd31 || fb_write_data !== 1'b1) begin
            errors++;
            $display("FAIL draw_addr31: we=%b addr=%0d data=%b, want 1 31 1", fb_write_enable, fb_write_addr, fb_write_data);
        end
        draw_addr = 5'd7; draw_data = 1'b0;
        tick();
        draw_valid = 1'b0;
        checks++;
        if (fb_write_enable !== 1'b1 || fb_write_addr !== 5'd7 || fb_write_data !== 1'b0) begin
            errors++;
            $display("FAIL draw_addr7: we=%b addr=%0d data=%b, want 1 7 0", fb_write_enable, fb_write_addr, fb_write_data);
        end
        tick();
        checks++;
        if (fb_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL draw_idle_we: we=%b, want 0", fb_write_enable);
        end
    endtask

    task automatic test_frame_start_ignored();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        checks++;
        if (draw_ready !== 1'b1 || busy !== 1'b1 || fb_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL frame_start_in_draw: ready=%b busy=%b we=%b, want 1 1 0", draw_ready, busy, fb_write_enable);
        end
    endtask

    // draw_done with a same-cycle write, then vblank 10 cycles later.
    task automatic test_vblank_swap();
        draw_done = 1'b1; draw_valid = 1'b1; draw_addr = 5'd9; draw_data = 1'b1;
        tick();
        draw_done = 1'b0; draw_valid = 1'b0;
        checks++;
        if (fb_write_enable !== 1'b1 || fb_write_addr !== 5'd9 || draw_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_with_write: we=%b addr=%0d ready=%b busy=%b, want 1 9 0 1",
                     fb_write_enable, fb_write_addr, draw_ready, busy);
        end
        for (int k = 0; k < 9; k++) begin
            tick();
            checks++;
            if (fb_swap !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL wait_no_swap[%0d]: swap=%b busy=%b, want 0 1", k, fb_swap, busy);
            end
        end
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        checks++;
        if (fb_swap !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL swap_pulse: swap=%b busy=%b, want 1 1", fb_swap, busy);
        end
        tick();
        checks++;
        if (fb_swap !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL swap_end: swap=%b busy=%b, want 0 0", fb_swap, busy);
        end
    endtask

    task automatic test_coincident_vblank();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int k = 0; k < 33; k++) tick();
        checks++;
        if (draw_ready !== 1'b1) begin
            errors++;
            $display("FAIL second_frame_draw: ready=%b, want 1", draw_ready);
        end
        draw_done = 1'b1; vblank_start = 1'b1;
        tick();
        draw_done = 1'b0; vblank_start = 1'b0;
        checks++;
        if (fb_swap !== 1'b0 || draw_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL coincident_vblank: swap=%b ready=%b busy=%b, want 0 0 1", fb_swap, draw_ready, busy);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (fb_swap !== 1'b0) begin
                errors++;
                $display("FAIL coincident_hold[%0d]: swap=%b, want 0", k, fb_swap);
            end
        end
        vblank_start = 1'b1;
        tick();
        vblank_start = 1'b0;
        checks++;
        if (fb_swap !== 1'b1) begin
            errors++;
            $display("FAIL next_vblank_swap: swap=%b, want 1", fb_swap);
        end
        tick();
        // Stray vblank / draw_done in IDLE must do nothing.
        vblank_start = 1'b1; draw_done = 1'b1;
        tick();
        vblank_start = 1'b0; draw_done = 1'b0;
        tick();
        checks++;
        if (fb_swap !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores: swap=%b busy=%b, want 0 0", fb_swap, busy);
        end
    endtask

    task automatic test_no_clear();
        frame_start2 = 1'b1;
        tick();
        frame_start2 = 1'b0;
        checks++;
        if (draw_ready2 !== 1'b1 || fb_write_enable2 !== 1'b0 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL noclear_entry: ready=%b we=%b busy=%b, want 1 0 1", draw_ready2, fb_write_enable2, busy2);
        end
        draw_valid2 = 1'b1; draw_addr2 = 6'd40; draw_data2 = 1'b1;
        tick();
        checks++;
        if (fb_write_enable2 !== 1'b0) begin
            errors++;
            $display("FAIL out_of_range_40: we=%b, want 0", fb_write_enable2);
        end
        draw_addr2 = 6'd39;
        tick();
        draw_valid2 = 1'b0;
        checks++;
        if (fb_write_enable2 !== 1'b1 || fb_write_addr2 !== 6'd39 || fb_write_data2 !== 1'b1) begin
            errors++;
            $display("FAIL in_range_39: we=%b addr=%0d data=%b, want 1 39 1", fb_write_enable2, fb_write_addr2, fb_write_data2);
        end
        draw_done2 = 1'b1;
        tick();
        draw_done2 = 1'b0;
        vblank_start2 = 1'b1;
        tick();
        vblank_start2 = 1'b0;
        checks++;
        if (fb_swap2 !== 1'b1) begin
            errors++;
            $display("FAIL noclear_swap: swap=%b, want 1", fb_swap2);
        end
        tick();
        checks++;
        if (busy2 !== 1'b0 || fb_swap2 !== 1'b0) begin
            errors++;
            $display("FAIL noclear_idle: busy=%b swap=%b, want 0 0", busy2, fb_swap2);
        end
    endtask

    task automatic test_reset_mid_clear();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int k = 0; k < 13; k++) tick();
        checks++;
        if (fb_write_enable !== 1'b1 || fb_write_addr !== 5'd12) begin
            errors++;
            $display("FAIL pre_reset_addr: we=%b addr=%0d, want 1 12", fb_write_enable, fb_write_addr);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fb_write_enable, fb_write_addr, fb_write_data, fb_swap, busy, draw_ready} !== 10'b0) begin
            errors++;
            $display("FAIL async_reset: we=%b addr=%0d data=%b swap=%b busy=%b ready=%b, want all 0",
                     fb_write_enable, fb_write_addr, fb_write_data, fb_swap, busy, draw_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (fb_swap !== 1'b0 || busy !== 1'b0 || fb_write_enable !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet[%0d]: swap=%b busy=%b we=%b, want 0 0 0", k, fb_swap, busy, fb_write_enable);
            end
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        checks++;
        if (fb_write_enable !== 1'b1 || fb_write_addr !== 5'd0 || fb_write_data !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: we=%b addr=%0d data=%b, want 1 0 0", fb_write_enable, fb_write_addr, fb_write_data);
        end
        tick();
        checks++;
        if (fb_write_addr !== 5'd1) begin
            errors++;
            $display("FAIL restart_clear_next: addr=%0d, want 1", fb_write_addr);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        frame_start  = 1'b0; draw_valid  = 1'b0; draw_addr  = '0; draw_data  = 1'b0;
        draw_done    = 1'b0; vblank_start = 1'b0;
        frame_start2 = 1'b0; draw_valid2 = 1'b0; draw_addr2 = '0; draw_data2 = 1'b0;
        draw_done2   = 1'b0; vblank_start2 = 1'b0;

        test_reset();
        test_clear();
        test_draw_write();
        test_frame_start_ignored();
        test_vblank_swap();
        test_coincident_vblank();
        test_no_clear();
        test_reset_mid_clear();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule : tb_frame_buffer_controller
`default_nettype wire
